aes_key_expand: RTL

Iterative on-the-fly AES-128 key schedule.
- Latches a 128-bit cipher key and presents round keys 0..10 one at a time on a registered output.
- Advances one round per `next` request.
- Sits directly upstream of `Add_round` and drives its `key` input.
- The round controller pulses `next` in the same cycle it asserts `add_round_en`, so each AddRoundKey consumes the key for the current round.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_sbox.sv | 38 +++
 rtl/aes_key_expand.sv | 138 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 constants, the key-schedule FSM state type and the GF(2^8)
// xtime helper. Imported by the S-box and the key-expansion block.
// ---------------------------------------------------------------------------
package aes_pkg;

  // Number of AES-128 rounds; round keys 0..NUM_ROUNDS are produced.
  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  // First round constant, used to derive round key 1.
  localparam logic [7:0] RCON_INIT  = 8'h01;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ks_state_e;

  // Multiply by x in GF(2^8); steps rcon 01,02,04,..,80,1B,36.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage : aes_pkg

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box (256-entry constant table).
// Ports:
//   in_byte   in  8  byte to substitute
//   out_byte  out 8  S-box(in_byte)
// ---------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  always_comb begin
    out_byte = SBOX[in_byte];
  end

endmodule : aes_sbox

// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand
// Iterative on-the-fly AES-128 key schedule. Loads a cipher key on `start`
// and steps through round keys 0..10, one per `next`, forward order only.
// Ports:
//   clk         in   1    system clock, rising edge
//   reset       in   1    synchronous active-low reset
//   start       in   1    load cipher_key, restart at round 0 (beats next)
//   cipher_key  in   128  AES key, byte 0 in [127:120]
//   next        in   1    consume current round key, advance one round
//   round_key   out  128  current round key (registered)
//   round_num   out  4    index of round_key, 0..10
//   key_valid   out  1    round_key valid for round_num
//   last_round  out  1    key_valid && round_num == 10
//   busy        out  1    FSM not IDLE
// ---------------------------------------------------------------------------
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipher_key,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         last_round,
  output logic         busy
);

  ks_state_e    state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_num_q, round_num_d;
  logic [7:0]   rcon_q, rcon_d;

  // -------------------------------------------------------------------------
  // Expand datapath: next round key from the current one, single cycle.
  // -------------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3, t_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] expanded_key;

  assign w0 = round_key_q[127:96];
  assign w1 = round_key_q[95:64];
  assign w2 = round_key_q[63:32];
  assign w3 = round_key_q[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_w3[8*b +: 8]),
      .out_byte (sub_w3[8*b +: 8])
    );
  end

  assign t_word = sub_w3 ^ {rcon_q, 24'h0};

  // Each new word chains off the previously computed new word.
  assign w0_n = w0 ^ t_word;
  assign w1_n = w1 ^ w0_n;
  assign w2_n = w2 ^ w1_n;
  assign w3_n = w3 ^ w2_n;

  assign expanded_key = {w0_n, w1_n, w2_n, w3_n};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_num_d = round_num_q;
    rcon_d      = rcon_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ACTIVE;
          round_key_d = cipher_key;
          round_num_d = 4'd0;
          rcon_d      = RCON_INIT;
        end
      end
      ACTIVE: begin
        if (start) begin
          round_key_d = cipher_key;
          round_num_d = 4'd0;
          rcon_d      = RCON_INIT;
        end else if (next) begin
          if (round_num_q < NUM_ROUNDS) begin
            round_key_d = expanded_key;
            round_num_d = round_num_q + 4'd1;
            rcon_d      = xtime(rcon_q);
          end else begin
            // Final key consumed; round_key is left as-is.
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments only in clocked blocks so every flop
  // samples pre-edge values regardless of statement order. The key register
  // is reset too, since it is a visible output that must read zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_num_q <= 4'd0;
      rcon_q      <= RCON_INIT;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_num_q <= round_num_d;
      rcon_q      <= rcon_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, all decoded from registers
  // -------------------------------------------------------------------------
  assign round_key  = round_key_q;
  assign round_num  = round_num_q;
  assign busy       = (state_q == ACTIVE);
  assign key_valid  = (state_q == ACTIVE);
  assign last_round = (state_q == ACTIVE) && (round_num_q == NUM_ROUNDS);

endmodule : aes_key_expand
